// File: rtl/mul32_column_accum_yjy_if.sv
// rtl/mul32_column_accum_yjy_if.sv - column-in / product-out handshake bundle for the column accumulator
interface mul32_column_accum_yjy_if;
    logic        start;
    logic        col_valid;
    logic        col_ready;
    logic [2:0]  col_idx;
    logic [15:0] col_sum;
    logic [7:0]  col_carry;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        err;

    modport master (
        output start, col_valid, col_idx, col_sum, col_carry, out_ready,
        input  col_ready, out_valid, product, err
    );

    modport slave (
        input  start, col_valid, col_idx, col_sum, col_carry, out_ready,
        output col_ready, out_valid, product, err
    );
endinterface

// File: rtl/mul32_column_accum_yjy.sv
// rtl/mul32_column_accum_yjy.sv - weights byte-column sum/carry results and accumulates the 64-bit product
module mul32_column_accum_yjy #(
    parameter int    UUID     = 0,
    parameter string NAME     = "",
    parameter int    NUM_COLS = 7
) (
    input logic                     clk,
    input logic                     rst,
    mul32_column_accum_yjy_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [7:0] FULL = 8'((1 << NUM_COLS) - 1);

    state_t      state;
    logic [63:0] acc;
    logic [63:0] term;
    logic [63:0] acc_next;
    logic [7:0]  mask;
    logic [7:0]  mask_next;
    logic [6:0]  sh;
    logic        accept;
    logic        in_range;
    logic        fresh;

    assign bus.col_ready = (state == ACCUM);

    // Shift amounts reach 72 for k=7; anything shifted past bit 63 is discarded.
    always_comb begin
        sh        = {1'b0, bus.col_idx, 3'b000};
        term      = ({48'b0, bus.col_sum} << sh) + ({56'b0, bus.col_carry} << (sh + 7'd16));
        accept    = bus.col_valid && bus.col_ready && !bus.start;
        in_range  = (int'(bus.col_idx) < NUM_COLS);
        fresh     = in_range && !mask[bus.col_idx];
        acc_next  = acc;
        mask_next = mask;
        if (accept && fresh) begin
            acc_next  = acc + term;
            mask_next = mask | (8'd1 << bus.col_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            mask          <= '0;
            bus.out_valid <= 1'b0;
            bus.product   <= '0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= ACCUM;
                        acc     <= '0;
                        mask    <= '0;
                        bus.err <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (bus.start) begin
                        acc     <= '0;
                        mask    <= '0;
                        bus.err <= 1'b0;
                    end else begin
                        acc  <= acc_next;
                        mask <= mask_next;
                        if (accept && !fresh) begin
                            bus.err <= 1'b1;
                        end
                        if (mask_next == FULL) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.product   <= acc_next;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (bus.start) begin
                            state   <= ACCUM;
                            acc     <= '0;
                            mask    <= '0;
                            bus.err <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
